// File: rtl/nibble_adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_adder_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_adder_seq_adder4.sv
// Single 4-bit ripple adder, time-shared by nibble_adder_seq across all nibbles.
module Adder4
   import nibble_adder_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] Z,
   output logic                Cout
);

   // 5-bit sum: the top bit is the carry into the next nibble
   always_comb begin
      {Cout, Z} = (NIBBLE_W+1)'(A) + (NIBBLE_W+1)'(B) + (NIBBLE_W+1)'(Cin);
   end

endmodule

// File: rtl/nibble_adder_seq.sv
// Nibble-serial adder: one 4-bit adder processes one nibble per cycle,
// finishing a W-bit addition in NIBBLES cycles followed by a one-cycle DONE.
module nibble_adder_seq
   import nibble_adder_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [4*NIBBLES-1:0]    a,
   input  logic [4*NIBBLES-1:0]    b,
   input  logic                    cin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NIBBLES-1:0]    sum,
   output logic                    cout,
   output logic                    ovf
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    ws_q, ws_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_z;
   logic                nib_co;
   logic                last_nib;

   Adder4 u_adder4 (
      .A    (nib_a),
      .B    (nib_b),
      .Cin  (carry_q),
      .Z    (nib_z),
      .Cout (nib_co)
   );

   // Index-based selection of the current operand nibbles
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
            nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   // Next-state, datapath updates and outputs
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      ws_d     = ws_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      last_nib = (idx_q == IW'(NIBBLES-1));
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            busy = 1'b1;
            for (int unsigned i = 0; i < NIBBLES; i++) begin
               if (idx_q == IW'(i)) begin
                  ws_d[i*NIBBLE_W +: NIBBLE_W] = nib_z;
               end
            end
            carry_d = nib_co;
            idx_d   = idx_q + 1'b1;
            if (last_nib) begin
               // ws_d already holds the final nibble, so its MSB is the result sign
               sum_d   = ws_d;
               cout_d  = nib_co;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (ws_d[W-1] != a_q[W-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ws_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ws_q    <= ws_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
